// File: rtl/target_centroid.sv
// target_centroid
//   Per-frame blob statistics for the colour-tracking path. Accumulates the
//   target-pixel count, coordinate sums and bounding box of a raster-order
//   pixel stream, then runs two parallel restoring dividers (x and y) on a
//   snapshot of the frame to produce the centroid.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   sof                     start-of-frame pulse (clears accumulators)
//   valid_in, is_target_in  pixel strobe and classification from the tracker
//   result_valid            one-cycle strobe, result registers just updated
//   detected                pixel_count >= MIN_PIXELS
//   pixel_count             target pixels in the frame
//   centroid_x/_y           floor(sum / count), 0 when count is 0
//   bbox_*                  bounding box, 0 when count is 0
//   busy                    divider running
module target_centroid #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int CNT_W      = 17,
  parameter int MIN_PIXELS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             valid_in,
  input  logic             is_target_in,
  output logic             result_valid,
  output logic             detected,
  output logic [CNT_W-1:0] pixel_count,
  output logic [X_W-1:0]   centroid_x,
  output logic [Y_W-1:0]   centroid_y,
  output logic [X_W-1:0]   bbox_x_min,
  output logic [X_W-1:0]   bbox_x_max,
  output logic [Y_W-1:0]   bbox_y_min,
  output logic [Y_W-1:0]   bbox_y_max,
  output logic             busy
);

  localparam int SX_W      = CNT_W + X_W;
  localparam int SY_W      = CNT_W + Y_W;
  localparam int DIV_STEPS = CNT_W + X_W;
  localparam int STEP_W    = $clog2(DIV_STEPS);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t state_r, next_state_s;

  logic [X_W-1:0]   x_r, x_min_r, x_max_r;
  logic [Y_W-1:0]   y_r, y_min_r, y_max_r;
  logic [CNT_W-1:0] count_r;
  logic [SX_W-1:0]  sum_x_r;
  logic [SY_W-1:0]  sum_y_r;

  // "base" is the accumulator view for the current pixel: cleared when sof
  // arrives in the same cycle, so that pixel lands at (0,0) of the new frame.
  logic [X_W-1:0]   base_x_s, base_x_min_s, base_x_max_s;
  logic [Y_W-1:0]   base_y_s, base_y_min_s, base_y_max_s;
  logic [CNT_W-1:0] base_count_s;
  logic [SX_W-1:0]  base_sum_x_s;
  logic [SY_W-1:0]  base_sum_y_s;

  logic [X_W-1:0]   x_nxt_s, x_min_nxt_s, x_max_nxt_s;
  logic [Y_W-1:0]   y_nxt_s, y_min_nxt_s, y_max_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [SX_W-1:0]  sum_x_nxt_s;
  logic [SY_W-1:0]  sum_y_nxt_s;

  logic accept_s, last_px_s;
  logic frame_end_r;

  // Divider state: snapshot of the finished frame plus the working registers.
  logic [CNT_W-1:0]     snap_cnt_r;
  logic [X_W-1:0]       snap_x_min_r, snap_x_max_r;
  logic [Y_W-1:0]       snap_y_min_r, snap_y_max_r;
  logic [CNT_W-1:0]     x_rem_r, y_rem_r;
  logic [DIV_STEPS-1:0] x_q_r, y_q_r;
  logic [STEP_W-1:0]    step_r;

  logic [CNT_W:0]       x_shift_s, y_shift_s;
  logic                 x_ge_s, y_ge_s;
  logic [CNT_W-1:0]     x_rem_nxt_s, y_rem_nxt_s;
  logic [DIV_STEPS-1:0] x_q_nxt_s, y_q_nxt_s;

  // Accumulator FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Accumulator FSM next-state logic; sof re-arms from any state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:  next_state_s = sof ? S_ACCUM : S_IDLE;
      S_ACCUM: next_state_s = S_ACCUM;
      default: next_state_s = S_IDLE;
    endcase
    if (last_px_s) begin
      next_state_s = S_IDLE;
    end else begin
      next_state_s = (sof && next_state_s == S_IDLE) ? S_ACCUM : next_state_s;
    end
  end

  // Accumulator FSM outputs: pixel acceptance and frame-end detection.
  always_comb begin
    accept_s  = valid_in && (sof || state_r == S_ACCUM);
    last_px_s = accept_s && (base_x_s == X_W'(IMG_W - 1)) &&
                (base_y_s == Y_W'(IMG_H - 1));
  end

  // Accumulator next values: apply sof clear, then the accepted pixel.
  always_comb begin
    if (sof) begin
      base_x_s     = '0;
      base_y_s     = '0;
      base_count_s = '0;
      base_sum_x_s = '0;
      base_sum_y_s = '0;
      base_x_min_s = X_W'(IMG_W - 1);
      base_x_max_s = '0;
      base_y_min_s = Y_W'(IMG_H - 1);
      base_y_max_s = '0;
    end else begin
      base_x_s     = x_r;
      base_y_s     = y_r;
      base_count_s = count_r;
      base_sum_x_s = sum_x_r;
      base_sum_y_s = sum_y_r;
      base_x_min_s = x_min_r;
      base_x_max_s = x_max_r;
      base_y_min_s = y_min_r;
      base_y_max_s = y_max_r;
    end

    x_nxt_s     = base_x_s;
    y_nxt_s     = base_y_s;
    count_nxt_s = base_count_s;
    sum_x_nxt_s = base_sum_x_s;
    sum_y_nxt_s = base_sum_y_s;
    x_min_nxt_s = base_x_min_s;
    x_max_nxt_s = base_x_max_s;
    y_min_nxt_s = base_y_min_s;
    y_max_nxt_s = base_y_max_s;

    if (accept_s) begin
      if (base_x_s == X_W'(IMG_W - 1)) begin
        x_nxt_s = '0;
        y_nxt_s = (base_y_s == Y_W'(IMG_H - 1)) ? '0 : base_y_s + Y_W'(1);
      end else begin
        x_nxt_s = base_x_s + X_W'(1);
        y_nxt_s = base_y_s;
      end
      if (is_target_in) begin
        count_nxt_s = base_count_s + CNT_W'(1);
        sum_x_nxt_s = base_sum_x_s + SX_W'(base_x_s);
        sum_y_nxt_s = base_sum_y_s + SY_W'(base_y_s);
        x_min_nxt_s = (base_x_s < base_x_min_s) ? base_x_s : base_x_min_s;
        x_max_nxt_s = (base_x_s > base_x_max_s) ? base_x_s : base_x_max_s;
        y_min_nxt_s = (base_y_s < base_y_min_s) ? base_y_s : base_y_min_s;
        y_max_nxt_s = (base_y_s > base_y_max_s) ? base_y_s : base_y_max_s;
      end else begin
        count_nxt_s = base_count_s;
      end
    end else begin
      x_nxt_s = base_x_s;
    end
  end

  // Accumulator registers and the frame-end pulse that triggers the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= '0;
      y_r         <= '0;
      count_r     <= '0;
      sum_x_r     <= '0;
      sum_y_r     <= '0;
      x_min_r     <= X_W'(IMG_W - 1);
      x_max_r     <= '0;
      y_min_r     <= Y_W'(IMG_H - 1);
      y_max_r     <= '0;
      frame_end_r <= 1'b0;
    end else begin
      x_r         <= x_nxt_s;
      y_r         <= y_nxt_s;
      count_r     <= count_nxt_s;
      sum_x_r     <= sum_x_nxt_s;
      sum_y_r     <= sum_y_nxt_s;
      x_min_r     <= x_min_nxt_s;
      x_max_r     <= x_max_nxt_s;
      y_min_r     <= y_min_nxt_s;
      y_max_r     <= y_max_nxt_s;
      frame_end_r <= last_px_s;
    end
  end

  // One restoring-division step for x and y. The y dividend is zero-extended
  // so both run the same number of steps. A zero divisor yields garbage that
  // is masked when the result is registered.
  always_comb begin
    x_shift_s   = {x_rem_r, x_q_r[DIV_STEPS-1]};
    y_shift_s   = {y_rem_r, y_q_r[DIV_STEPS-1]};
    x_ge_s      = (x_shift_s >= {1'b0, snap_cnt_r});
    y_ge_s      = (y_shift_s >= {1'b0, snap_cnt_r});
    x_rem_nxt_s = x_ge_s ? CNT_W'(x_shift_s - {1'b0, snap_cnt_r}) : x_shift_s[CNT_W-1:0];
    y_rem_nxt_s = y_ge_s ? CNT_W'(y_shift_s - {1'b0, snap_cnt_r}) : y_shift_s[CNT_W-1:0];
    x_q_nxt_s   = {x_q_r[DIV_STEPS-2:0], x_ge_s};
    y_q_nxt_s   = {y_q_r[DIV_STEPS-2:0], y_ge_s};
  end

  // Divider sequencing: a frame end (re)loads the snapshot, the final step
  // registers the held results and strobes result_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      step_r       <= '0;
      snap_cnt_r   <= '0;
      snap_x_min_r <= '0;
      snap_x_max_r <= '0;
      snap_y_min_r <= '0;
      snap_y_max_r <= '0;
      x_rem_r      <= '0;
      y_rem_r      <= '0;
      x_q_r        <= '0;
      y_q_r        <= '0;
      result_valid <= 1'b0;
      detected     <= 1'b0;
      pixel_count  <= '0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      bbox_x_min   <= '0;
      bbox_x_max   <= '0;
      bbox_y_min   <= '0;
      bbox_y_max   <= '0;
    end else begin
      result_valid <= 1'b0;
      if (frame_end_r) begin
        busy         <= 1'b1;
        step_r       <= '0;
        snap_cnt_r   <= count_r;
        snap_x_min_r <= x_min_r;
        snap_x_max_r <= x_max_r;
        snap_y_min_r <= y_min_r;
        snap_y_max_r <= y_max_r;
        x_rem_r      <= '0;
        y_rem_r      <= '0;
        x_q_r        <= DIV_STEPS'(sum_x_r);
        y_q_r        <= DIV_STEPS'(sum_y_r);
      end else if (busy) begin
        x_rem_r <= x_rem_nxt_s;
        y_rem_r <= y_rem_nxt_s;
        x_q_r   <= x_q_nxt_s;
        y_q_r   <= y_q_nxt_s;
        if (step_r == STEP_W'(DIV_STEPS - 1)) begin
          busy         <= 1'b0;
          step_r       <= '0;
          result_valid <= 1'b1;
          pixel_count  <= snap_cnt_r;
          detected     <= (snap_cnt_r >= CNT_W'(MIN_PIXELS));
          if (snap_cnt_r == '0) begin
            centroid_x <= '0;
            centroid_y <= '0;
            bbox_x_min <= '0;
            bbox_x_max <= '0;
            bbox_y_min <= '0;
            bbox_y_max <= '0;
          end else begin
            centroid_x <= x_q_nxt_s[X_W-1:0];
            centroid_y <= y_q_nxt_s[Y_W-1:0];
            bbox_x_min <= snap_x_min_r;
            bbox_x_max <= snap_x_max_r;
            bbox_y_min <= snap_y_min_r;
            bbox_y_max <= snap_y_max_r;
          end
        end else begin
          step_r <= step_r + STEP_W'(1);
        end
      end else begin
        step_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_target_centroid.sv
// Scoreboard bench for target_centroid on a reduced 32x24 frame.
module tb_target_centroid;

  localparam int IMG_W      = 32;
  localparam int IMG_H      = 24;
  localparam int X_W        = 9;
  localparam int Y_W        = 8;
  localparam int CNT_W      = 17;
  localparam int MIN_PIXELS = 64;
  localparam int LAT        = 27;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sof = 1'b0;
  logic             valid_in = 1'b0;
  logic             is_target_in = 1'b0;
  logic             result_valid, detected, busy;
  logic [CNT_W-1:0] pixel_count;
  logic [X_W-1:0]   centroid_x, bbox_x_min, bbox_x_max;
  logic [Y_W-1:0]   centroid_y, bbox_y_min, bbox_y_max;

  target_centroid #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W),
    .CNT_W(CNT_W), .MIN_PIXELS(MIN_PIXELS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in),
    .is_target_in(is_target_in), .result_valid(result_valid),
    .detected(detected), .pixel_count(pixel_count),
    .centroid_x(centroid_x), .centroid_y(centroid_y),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cnt; int cx; int cy; int bx0; int bx1; int by0; int by1; int det; int due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_tgt(input int mode, input int x, input int y);
    case (mode)
      1:       return (x == 10 && y == 20);
      2:       return (x >= 10 && x <= 17 && y >= 5 && y <= 12);
      3:       return 1'b1;
      4:       return (x == 5 && y == 5);
      5:       return (x == 0 && y == 0) || (x == 5 && y == 5);
      6:       return ((x * 7 + y * 3) % 11) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete frame and pushes the modelled result at its last pixel.
  task automatic drive_frame(input int mode, input bit sof_coinc, input bit push,
                             input int gap_after, input bit blank_lines);
    int    cnt = 0;
    longint sx = 0, sy = 0;
    int    x0 = IMG_W - 1, x1 = 0, y0 = IMG_H - 1, y1 = 0;
    exp_t  e;
    if (!sof_coinc) begin
      sof = 1'b1; valid_in = 1'b0;
      tick();
      sof = 1'b0;
    end
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        sof          = sof_coinc && x == 0 && y == 0;
        valid_in     = 1'b1;
        is_target_in = is_tgt(mode, x, y);
        if (is_target_in) begin
          cnt++; sx += x; sy += y;
          if (x < x0) x0 = x;
          if (x > x1) x1 = x;
          if (y < y0) y0 = y;
          if (y > y1) y1 = y;
        end
        tick();
        sof = 1'b0; valid_in = 1'b0; is_target_in = 1'b0;
        if (x == IMG_W - 1 && y == IMG_H - 1 && push) begin
          e.cnt = cnt;
          e.cx  = (cnt != 0) ? int'(sx / cnt) : 0;
          e.cy  = (cnt != 0) ? int'(sy / cnt) : 0;
          e.bx0 = (cnt != 0) ? x0 : 0;
          e.bx1 = (cnt != 0) ? x1 : 0;
          e.by0 = (cnt != 0) ? y0 : 0;
          e.by1 = (cnt != 0) ? y1 : 0;
          e.det = (cnt >= MIN_PIXELS) ? 1 : 0;
          e.due = cyc + LAT;
          sb_q.push_back(e);
        end
        if (blank_lines && x == IMG_W - 1 && !(y == IMG_H - 1))
          repeat ($urandom_range(0, 3)) tick();
      end
    end
    repeat (gap_after) tick();
  endtask

  // Starts a frame and abandons it after n pixels.
  task automatic drive_partial(input int n);
    sof = 1'b1; valid_in = 1'b0;
    tick();
    sof = 1'b0;
    for (int i = 0; i < n; i++) begin
      valid_in     = 1'b1;
      is_target_in = is_tgt(3, 0, 0);
      tick();
    end
    valid_in = 1'b0; is_target_in = 1'b0;
    tick();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_result_valid"}, result_valid, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_detected"}, detected, 0);
    check_eq({pfx, "_pixel_count"}, pixel_count, 0);
    check_eq({pfx, "_centroid_x"}, centroid_x, 0);
    check_eq({pfx, "_centroid_y"}, centroid_y, 0);
    check_eq({pfx, "_bbox_x_min"}, bbox_x_min, 0);
    check_eq({pfx, "_bbox_x_max"}, bbox_x_max, 0);
    check_eq({pfx, "_bbox_y_min"}, bbox_y_min, 0);
    check_eq({pfx, "_bbox_y_max"}, bbox_y_max, 0);
  endtask

  // Result monitor: every result_valid pops and checks one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_result_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("latency", cyc, mon_e.due);
        check_eq("pixel_count", pixel_count, mon_e.cnt);
        check_eq("centroid_x", centroid_x, mon_e.cx);
        check_eq("centroid_y", centroid_y, mon_e.cy);
        check_eq("bbox_x_min", bbox_x_min, mon_e.bx0);
        check_eq("bbox_x_max", bbox_x_max, mon_e.bx1);
        check_eq("bbox_y_min", bbox_y_min, mon_e.by0);
        check_eq("bbox_y_max", bbox_y_max, mon_e.by1);
        check_eq("detected", detected, mon_e.det);
        check_eq("busy_at_result", busy, 0);
      end
    end
  end

  initial begin
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    drive_frame(1, 1'b0, 1'b1, 40, 1'b0);   // single pixel at (10,20)
    drive_frame(2, 1'b0, 1'b1, 40, 1'b1);   // 8x8 block, exactly MIN_PIXELS
    drive_frame(0, 1'b0, 1'b1, 40, 1'b0);   // empty frame
    drive_frame(3, 1'b0, 1'b1, 40, 1'b0);   // every pixel a target
    drive_partial(100);                      // abandoned frame A
    drive_frame(4, 1'b0, 1'b1, 40, 1'b0);   // frame B, target at (5,5)
    drive_partial(50);
    drive_frame(5, 1'b1, 1'b1, 40, 1'b0);   // sof with first pixel
    drive_frame(6, 1'b0, 1'b1, 2, 1'b0);    // frame C, 2 blanking cycles
    drive_frame(2, 1'b1, 1'b1, 40, 1'b0);   // frame D during C's division

    // Reset in the middle of a division: no result, outputs cleared.
    drive_frame(1, 1'b0, 1'b0, 0, 1'b0);
    repeat (9) tick();
    check_eq("busy_mid_div", busy, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    drive_frame(6, 1'b0, 1'b1, 0, 1'b1);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    check_eq("scoreboard_drained", sb_q.size(), 0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/target_centroid.md
# target_centroid

Per-frame blob statistics for the colour-tracking path. Sits directly downstream of the HSV colour tracker and consumes its `valid_out`/`is_target_out` pixel stream in raster order. For each frame it accumulates the target-pixel count, coordinate sums and bounding box, then runs an iterative divider to produce the centroid. Results go to the overlay/servo-control logic as a one-cycle `result_valid` strobe with held result registers.

## Interface
- `IMG_W`, 320, active pixels per line
- `IMG_H`, 240, active lines per frame
- `X_W`, 9, x coordinate width
- `Y_W`, 8, y coordinate width
- `CNT_W`, 17, pixel counter width
- `MIN_PIXELS`, 64, minimum count for `detected`
- `clk`  in  1  single clock for the block
- `rst_n`  in  1  asynchronous active-low reset
- `sof`  in  1  start-of-frame pulse, one cycle
- `valid_in`  in  1  pixel strobe, from the tracker's `valid_out`
- `is_target_in`  in  1  pixel classification, from the tracker's `is_target_out`
- `result_valid`  out  1  one-cycle strobe, new results available
- `detected`  out  1  `pixel_count >= MIN_PIXELS`
- `pixel_count`  out  CNT_W  target pixels in the frame
- `centroid_x`  out  X_W  floor(sum_x / count)
- `centroid_y`  out  Y_W  floor(sum_y / count)
- `bbox_x_min`, `bbox_x_max`  out  X_W  horizontal bounding box
- `bbox_y_min`, `bbox_y_max`  out  Y_W  vertical bounding box
- `busy`  out  1  divider running

## Operation
- **Accumulator FSM: IDLE → ACCUM.**
  - `sof` in any state clears x, y, count, sum_x, sum_y, x_max and y_max to 0, sets x_min to `IMG_W-1` and y_min to `IMG_H-1`, and enters ACCUM.
  - `valid_in` is ignored in IDLE.
- **ACCUM, on each `valid_in` cycle:**
  - If `is_target_in=1`: count+1, sum_x+=x, sum_y+=y, and update min/max.
  - x increments. At `x==IMG_W-1`, x wraps to 0 and y increments.
  - When the pixel at (`IMG_W-1`, `IMG_H-1`) is accepted, this is frame end: snapshot the stats, FSM returns to IDLE, and the divider starts.
- **Edge cases:**
  - `sof` together with `valid_in`: counters clear and that pixel is accepted as (0,0) of the new frame.
  - `sof` before frame end discards the partial frame and produces no result.
- **Sum widths:** sum_x is CNT_W+X_W (26) bits, sum_y is CNT_W+Y_W (25) bits. Neither can overflow at the default sizes.
- **Divider:**
  - Restoring, one quotient bit per cycle. x and y run in parallel for DIV_STEPS = CNT_W+X_W = 26 iterations.
  - It operates on snapshot registers, so accumulation of the next frame proceeds concurrently.
  - A new frame end while `busy` restarts the divider with the new snapshot, and the old result is dropped.
  - Quotient truncates to X_W/Y_W bits.
- **count==0:**
  - Divider still runs, so timing is uniform.
  - centroid and bbox are output as 0, `detected`=0.
- **Results:** `detected`, `pixel_count`, centroid and bbox update only on the `result_valid` edge, and are held until the next one.

## Timing
- **Reset values:** all outputs are 0, both FSMs idle, and the accumulators hold their `sof`-clear values.
- **Result latency:** let L be the edge that accepts the last pixel of a frame.
  - Snapshot and `busy`=1 from L+1.
  - Division iterations occur on L+2 … L+27.
  - Results are registered and `result_valid`=1 on edge L+27, for exactly one cycle. `busy` falls at the same edge.
- **Divider throughput:** the minimum spacing between frame ends for no dropped result is 27 cycles, i.e. `valid_in` cycles plus blanking.
- **Reset mid-division:** aborts the division with no `result_valid`, and all outputs return to 0.
- **No handshake:** there is no backpressure. Pixels are accepted on every `valid_in` cycle.

## Test plan
- **Single pixel:** one target pixel at (10,20) in a full frame → count=1, centroid=(10,20), bbox x 10..10, y 20..20, detected=0, `result_valid` at L+27.
- **8x8 block:** all pixels of x 100..107, y 50..57 are targets → count=64, detected=1, centroid=(103,53) (floor of 103.5/53.5), bbox x 100..107, y 50..57.
- **Empty frame:** no targets → count=0, centroid 0, bbox 0, detected=0. `result_valid` still pulses once.
- **Full frame:** every pixel is a target → count=76800, centroid=(159,119), bbox 0..319 / 0..239, detected=1.
- **Partial frame, then a new frame:**
  - `sof` after 1000 pixels of frame A, then a complete frame B with one target pixel at (5,5) → no result for A, a single result for B with centroid (5,5).
  - Also `sof` coincident with the first `valid_in` of B → that pixel is accepted as (0,0).
- **Back-to-back frames and mid-division reset:**
  - Frame C ends and frame D starts with 2 blanking cycles → D accumulates during C's division, and C's result is correct.
  - Deassert `rst_n` at L+10 → no `result_valid`, all outputs 0, and the next full frame works normally.
